// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, coordinate scale encoding and raster total helper
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COORD_W  = 10;

  // Encoded value doubles as the coordinate right-shift amount.
  typedef enum logic [1:0] {
    SCALE_1 = 2'd0,
    SCALE_2 = 2'd1,
    SCALE_4 = 2'd2
  } scale_e;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // The reserved encoding falls back to 1:1.
  function automatic scale_e decode_scale(input logic [1:0] sel);
    case (sel)
      2'd1:    return SCALE_2;
      2'd2:    return SCALE_4;
      default: return SCALE_1;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the timing generator and its consumers (frame-buffer
// reader, renderer): scale request in, raster strobes and coordinates out.
interface vga_timing_if #(
  parameter int COORD_W = 10
);
  // No valid/ready here: every output below is held for a whole pixel period
  // and is qualified by pclk_en, so consumers sample on clk edges where
  // pclk_en is high. scale_sel may change at any time.
  logic [1:0]         scale_sel;
  logic               pclk_en;
  logic               h_sync;
  logic               v_sync;
  logic               DE;
  logic [COORD_W-1:0] x_pixel;
  logic [COORD_W-1:0] y_pixel;
  logic               line_start;
  logic               frame_start;

  modport master (
    input  scale_sel,
    output pclk_en, h_sync, v_sync, DE, x_pixel, y_pixel, line_start, frame_start
  );

  modport slave (
    output scale_sel,
    input  pclk_en, h_sync, v_sync, DE, x_pixel, y_pixel, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen_tick.sv
// Pixel-clock enable divider: one-cycle pulse every CLK_DIV system clocks,
// first pulse on the CLK_DIV-th edge after reset release.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pclk_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pclk_en <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      pclk_en <= (div_cnt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: raster counters, sync/DE decode,
// per-frame coordinate downscale and pixel-tick registered outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int COORD_W    = DEF_COORD_W
) (
  input logic         clk,
  input logic         reset,
  vga_timing_if.master bus
);

  localparam int H_TOTAL      = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL      = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic               pclk_en;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  scale_e             scale_q;

  logic               h_sync_d, v_sync_d, de_d, line_d, frame_d;
  logic [COORD_W-1:0] x_d, y_d;

  logic               h_sync_q, v_sync_q, de_q, line_q, frame_q;
  logic [COORD_W-1:0] x_q, y_q;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .pclk_en (pclk_en)
  );

  // Scale is sampled on the last pixel of a frame so a frame never mixes scales.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      scale_q <= SCALE_1;
    end else if (pclk_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt   <= '0;
          scale_q <= decode_scale(bus.scale_sel);
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    de_d     = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    h_sync_d = ((int'(h_cnt) >= H_SYNC_START) && (int'(h_cnt) < H_SYNC_END))
               ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_d = ((int'(v_cnt) >= V_SYNC_START) && (int'(v_cnt) < V_SYNC_END))
               ? V_SYNC_POL : ~V_SYNC_POL;
    x_d      = '0;
    y_d      = '0;
    if (de_d) begin
      x_d = h_cnt >> scale_q;
      y_d = v_cnt >> scale_q;
    end
    line_d  = (h_cnt == '0);
    frame_d = line_d && (v_cnt == '0);
  end

  // Outputs show the decode of the position held just before each pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync_q <= ~H_SYNC_POL;
      v_sync_q <= ~V_SYNC_POL;
      de_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else if (pclk_en) begin
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      de_q     <= de_d;
      x_q      <= x_d;
      y_q      <= y_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.pclk_en     = pclk_en;
  assign bus.h_sync      = h_sync_q;
  assign bus.v_sync      = v_sync_q;
  assign bus.DE          = de_q;
  assign bus.x_pixel     = x_q;
  assign bus.y_pixel     = y_q;
  assign bus.line_start  = line_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default 640x480, a small
// CLK_DIV=3 raster and a tiny CLK_DIV=1 positive-sync raster).
module tb_vga_timing_gen;

  typedef struct packed {
    int cd; int ha; int hf; int hsy; int hb; int va; int vf; int vsy; int vb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct packed {
    logic pclk_en; logic hs; logic vs; logic de;
    logic [9:0] x; logic [9:0] y; logic ls; logic fs;
  } obs_t;

  typedef struct packed {
    int h; int v; logic hs; logic vs; logic de;
    logic [9:0] x; logic [9:0] y; logic ls; logic fs;
  } vec_t;

  localparam cfg_t CFG_D = '{cd:4, ha:640, hf:16, hsy:96, hb:48, va:480, vf:10, vsy:2, vb:33, hp:1'b0, vp:1'b0};
  localparam cfg_t CFG_M = '{cd:3, ha:16, hf:2, hsy:4, hb:2, va:12, vf:1, vsy:2, vb:2, hp:1'b0, vp:1'b0};
  localparam cfg_t CFG_S = '{cd:1, ha:8, hf:2, hsy:3, hb:3, va:4, vf:1, vsy:1, vb:1, hp:1'b1, vp:1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b0, rst_m = 1'b0, rst_s = 1'b0;
  int checks = 0, errors = 0;
  int k_d = 0, k_m = 0, k_s = 0;
  int sc_d = 0, sc_m = 0, sc_s = 0;

  vga_timing_if #(.COORD_W(10)) if_d ();
  vga_timing_if #(.COORD_W(10)) if_m ();
  vga_timing_if #(.COORD_W(10)) if_s ();

  vga_timing_gen #(.CLK_DIV(CFG_D.cd), .H_ACTIVE(CFG_D.ha), .H_FP(CFG_D.hf), .H_SYNC(CFG_D.hsy),
    .H_BP(CFG_D.hb), .V_ACTIVE(CFG_D.va), .V_FP(CFG_D.vf), .V_SYNC(CFG_D.vsy), .V_BP(CFG_D.vb),
    .H_SYNC_POL(CFG_D.hp), .V_SYNC_POL(CFG_D.vp), .COORD_W(10))
    u_dut_d (.clk(clk), .reset(rst_d), .bus(if_d));

  vga_timing_gen #(.CLK_DIV(CFG_M.cd), .H_ACTIVE(CFG_M.ha), .H_FP(CFG_M.hf), .H_SYNC(CFG_M.hsy),
    .H_BP(CFG_M.hb), .V_ACTIVE(CFG_M.va), .V_FP(CFG_M.vf), .V_SYNC(CFG_M.vsy), .V_BP(CFG_M.vb),
    .H_SYNC_POL(CFG_M.hp), .V_SYNC_POL(CFG_M.vp), .COORD_W(10))
    u_dut_m (.clk(clk), .reset(rst_m), .bus(if_m));

  vga_timing_gen #(.CLK_DIV(CFG_S.cd), .H_ACTIVE(CFG_S.ha), .H_FP(CFG_S.hf), .H_SYNC(CFG_S.hsy),
    .H_BP(CFG_S.hb), .V_ACTIVE(CFG_S.va), .V_FP(CFG_S.vf), .V_SYNC(CFG_S.vsy), .V_BP(CFG_S.vb),
    .H_SYNC_POL(CFG_S.hp), .V_SYNC_POL(CFG_S.vp), .COORD_W(10))
    u_dut_s (.clk(clk), .reset(rst_s), .bus(if_s));

  // ---------------- reference model ----------------
  function automatic int h_tot(input cfg_t c); return c.ha + c.hf + c.hsy + c.hb; endfunction
  function automatic int v_tot(input cfg_t c); return c.va + c.vf + c.vsy + c.vb; endfunction

  // Clock edges after release at which pixel (h,v) of frame f is on the outputs.
  function automatic int k_of(input cfg_t c, input int f, input int h, input int v);
    return c.cd * (f * h_tot(c) * v_tot(c) + v * h_tot(c) + h + 1) + 1;
  endfunction

  // True when the edge following k edges consumes the last pixel of a frame.
  function automatic bit is_capture(input int k, input cfg_t c);
    int ft;
    ft = h_tot(c) * v_tot(c);
    return (k >= c.cd) && (k % c.cd == 0) && (((k / c.cd - 1) % ft) == ft - 1);
  endfunction

  function automatic obs_t model(input int k, input cfg_t c, input int sc);
    obs_t o;
    int l, p, h, v;
    o.pclk_en = (k >= c.cd) && (k % c.cd == 0);
    o.hs = ~c.hp; o.vs = ~c.vp; o.de = 1'b0;
    o.x = '0; o.y = '0; o.ls = 1'b0; o.fs = 1'b0;
    if (k > c.cd) begin
      l = (k - 1) / c.cd;
      p = (l - 1) % (h_tot(c) * v_tot(c));
      h = p % h_tot(c);
      v = p / h_tot(c);
      o.de = (h < c.ha) && (v < c.va);
      o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsy) ? c.hp : ~c.hp;
      o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsy) ? c.vp : ~c.vp;
      o.x  = o.de ? 10'(h >> sc) : 10'd0;
      o.y  = o.de ? 10'(v >> sc) : 10'd0;
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
    end
    return o;
  endfunction

  function automatic int map_scale(input logic [1:0] s);
    return (s == 2'd3) ? 0 : int'(s);
  endfunction

  always @(posedge clk or posedge rst_d)
    if (rst_d) begin k_d <= 0; sc_d <= 0; end
    else begin
      if (is_capture(k_d, CFG_D)) sc_d <= map_scale(if_d.scale_sel);
      k_d <= k_d + 1;
    end

  always @(posedge clk or posedge rst_m)
    if (rst_m) begin k_m <= 0; sc_m <= 0; end
    else begin
      if (is_capture(k_m, CFG_M)) sc_m <= map_scale(if_m.scale_sel);
      k_m <= k_m + 1;
    end

  always @(posedge clk or posedge rst_s)
    if (rst_s) begin k_s <= 0; sc_s <= 0; end
    else begin
      if (is_capture(k_s, CFG_S)) sc_s <= map_scale(if_s.scale_sel);
      k_s <= k_s + 1;
    end

  // ---------------- scoreboard helpers ----------------
  task automatic chk_obs(input string name, input int k, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s k=%0d got pclk/hs/vs/de=%b%b%b%b x=%0d y=%0d ls/fs=%b%b want %b%b%b%b x=%0d y=%0d ls/fs=%b%b",
               name, k, a.pclk_en, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs,
               e.pclk_en, e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int cur_k(input int which);
    return (which == 0) ? k_d : (which == 1) ? k_m : k_s;
  endfunction

  task automatic wait_k(input int which, input int target);
    int guard = 0;
    while (cur_k(which) < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("wait_k_dut%0d", which), cur_k(which), target);
  endtask

  always @(negedge clk) begin
    obs_t a;
    a = {if_d.pclk_en, if_d.h_sync, if_d.v_sync, if_d.DE, if_d.x_pixel, if_d.y_pixel, if_d.line_start, if_d.frame_start};
    chk_obs("mon_def", k_d, a, model(k_d, CFG_D, sc_d));
  end

  always @(negedge clk) begin
    obs_t a;
    a = {if_m.pclk_en, if_m.h_sync, if_m.v_sync, if_m.DE, if_m.x_pixel, if_m.y_pixel, if_m.line_start, if_m.frame_start};
    chk_obs("mon_mid", k_m, a, model(k_m, CFG_M, sc_m));
  end

  always @(negedge clk) begin
    obs_t a;
    a = {if_s.pclk_en, if_s.h_sync, if_s.v_sync, if_s.DE, if_s.x_pixel, if_s.y_pixel, if_s.line_start, if_s.frame_start};
    chk_obs("mon_small", k_s, a, model(k_s, CFG_S, sc_s));
  end

  // ---------------- stimulus ----------------
  vec_t vecs[13];
  obs_t act;
  int n, nh, nv, nde, guard;
  bit seen_low;

  initial begin
    // Hand-derived positions in the small raster (sync asserted high).
    vecs[0]  = '{h:0,  v:0, hs:0, vs:0, de:1, x:0, y:0, ls:1, fs:1};
    vecs[1]  = '{h:5,  v:2, hs:0, vs:0, de:1, x:5, y:2, ls:0, fs:0};
    vecs[2]  = '{h:7,  v:3, hs:0, vs:0, de:1, x:7, y:3, ls:0, fs:0};
    vecs[3]  = '{h:8,  v:3, hs:0, vs:0, de:0, x:0, y:0, ls:0, fs:0};
    vecs[4]  = '{h:9,  v:1, hs:0, vs:0, de:0, x:0, y:0, ls:0, fs:0};
    vecs[5]  = '{h:10, v:1, hs:1, vs:0, de:0, x:0, y:0, ls:0, fs:0};
    vecs[6]  = '{h:12, v:4, hs:1, vs:0, de:0, x:0, y:0, ls:0, fs:0};
    vecs[7]  = '{h:13, v:0, hs:0, vs:0, de:0, x:0, y:0, ls:0, fs:0};
    vecs[8]  = '{h:0,  v:4, hs:0, vs:0, de:0, x:0, y:0, ls:1, fs:0};
    vecs[9]  = '{h:3,  v:5, hs:0, vs:1, de:0, x:0, y:0, ls:0, fs:0};
    vecs[10] = '{h:11, v:5, hs:1, vs:1, de:0, x:0, y:0, ls:0, fs:0};
    vecs[11] = '{h:15, v:6, hs:0, vs:0, de:0, x:0, y:0, ls:0, fs:0};
    vecs[12] = '{h:0,  v:6, hs:0, vs:0, de:0, x:0, y:0, ls:1, fs:0};

    if_d.scale_sel = 2'd0; if_m.scale_sel = 2'd0; if_s.scale_sel = 2'd0;
    #1;
    rst_d = 1'b1; rst_m = 1'b1; rst_s = 1'b1;

    // Default raster: reset values, then first tick and first frame_start.
    repeat (5) @(posedge clk);
    @(negedge clk);
    act = {if_d.pclk_en, if_d.h_sync, if_d.v_sync, if_d.DE, if_d.x_pixel, if_d.y_pixel, if_d.line_start, if_d.frame_start};
    chk_obs("def_reset", 0, act, '{pclk_en:0, hs:1, vs:1, de:0, x:0, y:0, ls:0, fs:0});
    rst_d = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("def_first_pclk_edge%0d", i), if_d.pclk_en, (i == 4));
    end
    @(negedge clk);
    act = {if_d.pclk_en, if_d.h_sync, if_d.v_sync, if_d.DE, if_d.x_pixel, if_d.y_pixel, if_d.line_start, if_d.frame_start};
    chk_obs("def_first_pixel", 5, act, '{pclk_en:0, hs:1, vs:1, de:1, x:0, y:0, ls:1, fs:1});

    // Small raster: table of positions, each reached from a fresh reset.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      #2 rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      repeat (vecs[i].v * 16 + vecs[i].h + 2) @(posedge clk);
      @(negedge clk);
      act = {if_s.pclk_en, if_s.h_sync, if_s.v_sync, if_s.DE, if_s.x_pixel, if_s.y_pixel, if_s.line_start, if_s.frame_start};
      chk_obs($sformatf("small_vec%0d", i), vecs[i].v * 16 + vecs[i].h + 2, act,
              '{pclk_en:1, hs:vecs[i].hs, vs:vecs[i].vs, de:vecs[i].de, x:vecs[i].x, y:vecs[i].y,
                ls:vecs[i].ls, fs:vecs[i].fs});
    end

    // Small raster: frame period and per-frame sync/DE occupancy.
    guard = 0;
    while (!if_s.frame_start && guard < 300) begin @(negedge clk); guard++; end
    n = 0; nh = 0; nv = 0; nde = 0;
    do begin
      nh += int'(if_s.h_sync); nv += int'(if_s.v_sync); nde += int'(if_s.DE);
      @(negedge clk);
      n++;
    end while (!if_s.frame_start && n < 1000);
    chk("small_frame_period", n, 112);
    chk("small_hsync_count", nh, 21);
    chk("small_vsync_count", nv, 16);
    chk("small_de_count", nde, 32);

    // Default raster: h_sync edges on line 0 and the start of line 1.
    wait_k(0, k_of(CFG_D, 0, 655, 0)); chk("def_hs_655", if_d.h_sync, 1);
    wait_k(0, k_of(CFG_D, 0, 656, 0)); chk("def_hs_656", if_d.h_sync, 0);
    wait_k(0, k_of(CFG_D, 0, 751, 0)); chk("def_hs_751", if_d.h_sync, 0);
    wait_k(0, k_of(CFG_D, 0, 752, 0)); chk("def_hs_752", if_d.h_sync, 1);
    wait_k(0, k_of(CFG_D, 0, 0, 1));
    act = {if_d.pclk_en, if_d.h_sync, if_d.v_sync, if_d.DE, if_d.x_pixel, if_d.y_pixel, if_d.line_start, if_d.frame_start};
    chk_obs("def_line1", k_d, act, '{pclk_en:0, hs:1, vs:1, de:1, x:0, y:1, ls:1, fs:0});

    // Mid raster: scale change mid-frame takes effect only at the next frame.
    @(negedge clk);
    rst_m = 1'b0;
    wait_k(1, k_of(CFG_M, 0, 0, 5));   if_m.scale_sel = 2'd1;
    wait_k(1, k_of(CFG_M, 0, 15, 11)); chk("mid_f0_x", if_m.x_pixel, 15); chk("mid_f0_y", if_m.y_pixel, 11);
    wait_k(1, k_of(CFG_M, 1, 15, 11)); chk("mid_f1_x", if_m.x_pixel, 7);  chk("mid_f1_y", if_m.y_pixel, 5);
    wait_k(1, k_of(CFG_M, 1, 0, 14));  if_m.scale_sel = 2'd3;
    wait_k(1, k_of(CFG_M, 2, 15, 0));  chk("mid_f2_x_reserved", if_m.x_pixel, 15); chk("mid_f2_de", if_m.DE, 1);

    // Mid raster: asynchronous reset mid-frame, then restart at (0,0).
    wait_k(1, k_of(CFG_M, 2, 5, 8));
    #2 rst_m = 1'b1;
    #1;
    act = {if_m.pclk_en, if_m.h_sync, if_m.v_sync, if_m.DE, if_m.x_pixel, if_m.y_pixel, if_m.line_start, if_m.frame_start};
    chk_obs("mid_async_reset", 0, act, '{pclk_en:0, hs:1, vs:1, de:0, x:0, y:0, ls:0, fs:0});
    repeat (3) @(negedge clk);
    rst_m = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    act = {if_m.pclk_en, if_m.h_sync, if_m.v_sync, if_m.DE, if_m.x_pixel, if_m.y_pixel, if_m.line_start, if_m.frame_start};
    chk_obs("mid_restart", 4, act, '{pclk_en:0, hs:1, vs:1, de:1, x:0, y:0, ls:1, fs:1});

    // Mid raster: frame_start rising-edge period in clocks.
    n = 0; seen_low = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!if_m.frame_start) seen_low = 1'b1;
    end while (!(seen_low && if_m.frame_start) && n < 5000);
    seen_low = 1'b0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!if_m.frame_start) seen_low = 1'b1;
    end while (!(seen_low && if_m.frame_start) && n < 5000);
    chk("mid_frame_period", n, 1224);

    // Random scale requests and asynchronous reset pulses; monitors check every cycle.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      case ($urandom_range(0, 5))
        0, 1: if_m.scale_sel = 2'($urandom_range(0, 3));
        2, 3: if_s.scale_sel = 2'($urandom_range(0, 3));
        4: begin
          #($urandom_range(1, 4)) rst_m = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          rst_m = 1'b0;
        end
        default: begin
          #($urandom_range(1, 4)) rst_s = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          rst_s = 1'b0;
        end
      endcase
    end

    repeat (20) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 decoder. It divides the system clock into a single-cycle pixel-clock enable rather than a derived clock. It generates polarity-configurable h_sync/v_sync, DE, frame and line start strobes, and pixel coordinates that can be downscaled per frame. It sits between the system clock domain and the frame-buffer read / game renderer logic, which consume coordinates and strobes qualified by pclk_en.

## Interface
- CLK_DIV, 4: system clocks per pixel; >= 1
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines
- H_SYNC_POL, 0 / V_SYNC_POL, 0: asserted sync level (0 = active-low)
- COORD_W, 10: counter/coordinate width; requires H_TOTAL, V_TOTAL <= 2**COORD_W
- clk  in  1  system clock; the block's only clock
- reset  in  1  asynchronous, active-high reset
- scale_sel  in  2  coordinate downscale: 0 = 1:1, 1 = /2, 2 = /4, 3 = reserved (treated as 0)
- pclk_en  out  1  pixel-clock enable, high one clk cycle every CLK_DIV cycles
- h_sync  out  1  horizontal sync, level per H_SYNC_POL
- v_sync  out  1  vertical sync, level per V_SYNC_POL
- DE  out  1  display enable (active area)
- x_pixel  out  COORD_W  scaled column; 0 when DE low
- y_pixel  out  COORD_W  scaled row; 0 when DE low
- line_start  out  1  high for the pixel period of h = 0 (every line)
- frame_start  out  1  high for the pixel period of (h,v) = (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider: div_cnt runs 0..CLK_DIV-1. pclk_en is registered high when div_cnt = CLK_DIV-1. With CLK_DIV = 1, pclk_en is high on every cycle after reset.
- Raster counters h_cnt and v_cnt advance only on cycles with pclk_en high.
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0.
- Decode from the current (h_cnt, v_cnt):
  - DE = h < H_ACTIVE and v < V_ACTIVE.
  - h_sync is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; v_sync uses the same rule vertically.
  - line_start = (h == 0); frame_start = line_start and v == 0.
- Scaling: scale_q is captured from scale_sel only on the pclk_en where (h,v) = (H_TOTAL-1, V_TOTAL-1). Changes to scale_sel therefore take effect at the next frame start, never mid-frame. x_pixel = h >> scale_q and y_pixel = v >> scale_q when DE is high; otherwise both are 0.
- Reset, asynchronous at any time including mid-frame:
  - div_cnt, h_cnt, v_cnt, scale_q = 0; pclk_en = 0.
  - h_sync = !H_SYNC_POL and v_sync = !V_SYNC_POL (inactive).
  - DE, x_pixel, y_pixel, line_start, frame_start = 0.
- After reset release, the raster restarts from (0,0) with no partial frame.

## Timing
- First pclk_en is at the CLK_DIV-th rising clk edge after reset deassertion.
- All outputs except pclk_en are registered and load only on pclk_en cycles. Latency is one pixel tick: after the pclk_en edge, outputs show the decode of the counter values held before that edge.
- Outputs are stable for a full pixel period (CLK_DIV clks). Consumers sample them on pclk_en.
- The first frame_start is visible immediately after the first pclk_en edge, together with DE = 1 and x = y = 0.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks (default 1,680,000).

## Structure
- Package vga_timing_pkg holds:
  - default timing localparams (the 640x480@60 values above);
  - the scale_e enum (SCALE_1, SCALE_2, SCALE_4);
  - a function computing H_TOTAL and V_TOTAL.
- Sub-module pixel_tick_gen: the CLK_DIV enable divider, parameter CLK_DIV, ports clk, reset, pclk_en.
- Top level contains the raster counters, decode, scale_q, and output registers.

## Test plan
- Reset at default parameters, reset held 5 clks: all outputs at reset values (h_sync = v_sync = 1, DE = 0); first pclk_en 4 clks after release, then frame_start = 1, DE = 1, x = y = 0.
- Full default frame: h_sync low exactly 96 pixel periods starting at pixel 656 of each line; v_sync low for lines 490-491; DE high 640x480 pixel periods; frame_start period = 1,680,000 clks.
- scale_sel = 1 driven at mid-frame line 100: x/y unchanged (1:1) for the rest of that frame; next frame pixel (639,479) reports x = 319, y = 239.
- scale_sel = 3 at frame boundary: behaves as 1:1 (x_pixel = 639 at h = 639).
- Reset asserted at line 300, pixel 200, for 3 clks: outputs return to reset values asynchronously; after release, raster restarts at (0,0) with frame_start.
- Overrides CLK_DIV = 1, H_ACTIVE=8/FP=2/SYNC=3/BP=3, V_ACTIVE=4/FP=1/SYNC=1/BP=1, H_SYNC_POL = V_SYNC_POL = 1: pclk_en constant high; h_sync high at h = 10..12; v_sync high at v = 5; frame period 112 clks.
